// File: rtl/da_control_gen.sv
// da_control_gen: valid/ready sequencing FSM for a distributed-arithmetic FIR datapath.
// All controls are registered on the falling edge so the datapath samples them stable on the rising edge.
module da_control_gen #(
    parameter int DATA_W    = 16,
    parameter int NPART     = 4,
    parameter int ROM_WORDS = 64,
    parameter int SIGNED    = 1,
    localparam int BW = $clog2(DATA_W),
    localparam int AW = $clog2(ROM_WORDS),
    localparam int KW = (NPART > 1) ? $clog2(NPART) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cload,
    input  logic             coef_valid,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             load_sreg,
    output logic             clr_acc,
    output logic             shift_sreg,
    output logic [NPART-1:0] do_w,
    output logic             do_sum,
    output logic             do_acc,
    output logic             acc_sub,
    output logic [BW-1:0]    bit_idx,
    output logic             busy,
    output logic             rom_cen,
    output logic             rom_wen,
    output logic [AW-1:0]    rom_addr,
    output logic             rom_loaded
);
    localparam int STRIDE = ROM_WORDS / NPART;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOOKUP, S_SUM, S_ACC, S_SHIFT, S_DONE} state_t;

    state_t        r_state, w_nstate;
    logic [KW-1:0] r_k, w_k;
    logic [AW-1:0] r_waddr, w_wptr;
    logic          w_write, w_wrap, w_loaded;

    // A low rom_wen means the previous cycle wrote, so the write pointer advances now
    always_comb begin
        w_nstate = r_state;
        w_k      = r_k;
        w_write  = 1'b0;
        w_wrap   = !rom_wen && r_waddr == AW'(ROM_WORDS - 1);
        w_wptr   = rom_wen ? r_waddr : w_wrap ? '0 : r_waddr + 1'b1;
        w_loaded = rom_loaded | w_wrap;
        case (r_state)
            S_IDLE:
                if (cload) w_write = coef_valid;
                else if (in_valid && in_ready) w_nstate = S_FETCH;
            S_FETCH, S_SHIFT: begin
                w_nstate = S_LOOKUP;
                w_k      = '0;
            end
            S_LOOKUP:
                if (r_k == KW'(NPART - 1)) w_nstate = S_SUM;
                else w_k = r_k + 1'b1;
            S_SUM:   w_nstate = S_ACC;
            S_ACC:   w_nstate = (bit_idx == BW'(DATA_W - 1)) ? S_DONE : S_SHIFT;
            S_DONE:  if (out_ready) w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_waddr    <= '0;
            rom_loaded <= 1'b0;
            bit_idx    <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            load_sreg  <= 1'b0;
            clr_acc    <= 1'b0;
            shift_sreg <= 1'b0;
            do_w       <= '0;
            do_sum     <= 1'b0;
            do_acc     <= 1'b0;
            acc_sub    <= 1'b0;
            busy       <= 1'b0;
            rom_cen    <= 1'b1;
            rom_wen    <= 1'b1;
            rom_addr   <= '0;
        end else begin
            r_state    <= w_nstate;
            r_k        <= w_k;
            r_waddr    <= w_wptr;
            rom_loaded <= w_loaded;
            bit_idx    <= (w_nstate == S_FETCH) ? '0 : (w_nstate == S_SHIFT) ? bit_idx + 1'b1 : bit_idx;
            in_ready   <= w_nstate == S_IDLE && w_loaded && !cload;
            out_valid  <= w_nstate == S_DONE;
            load_sreg  <= w_nstate == S_FETCH;
            clr_acc    <= w_nstate == S_FETCH;
            shift_sreg <= w_nstate == S_SHIFT;
            do_w       <= (w_nstate == S_LOOKUP) ? NPART'(1) << w_k : '0;
            do_sum     <= w_nstate == S_SUM;
            do_acc     <= w_nstate == S_ACC;
            acc_sub    <= w_nstate == S_ACC && SIGNED != 0 && bit_idx == BW'(DATA_W - 1);
            busy       <= w_nstate != S_IDLE;
            rom_cen    <= !(w_write || w_nstate == S_LOOKUP);
            rom_wen    <= !w_write;
            rom_addr   <= (w_nstate == S_LOOKUP) ? AW'(int'(w_k) * STRIDE) :
                          (w_nstate == S_IDLE) ? w_wptr : '0;
        end
    end
endmodule

// File: tb/tb_da_control_gen.sv
// tb_da_control_gen: checks the default and a narrow unsigned configuration against a schedule model.
module tb_da_control_gen;
    logic clk = 0, resetn = 0, cload = 0, coef_valid = 0, in_valid = 0, out_ready = 0;
    always #5 clk = ~clk;

    logic ir0, ov0, ls0, ca0, ss0, sm0, ac0, sb0, bs0, cn0, wn0, lo0;
    logic [3:0] dw0, bt0;
    logic [5:0] ad0;
    logic ir1, ov1, ls1, ca1, ss1, sm1, ac1, sb1, bs1, cn1, wn1, lo1;
    logic [1:0] dw1;
    logic [2:0] bt1;
    logic [5:0] ad1;

    da_control_gen dut0 (
        .clk(clk), .resetn(resetn), .cload(cload), .coef_valid(coef_valid), .in_valid(in_valid),
        .in_ready(ir0), .out_valid(ov0), .out_ready(out_ready), .load_sreg(ls0), .clr_acc(ca0),
        .shift_sreg(ss0), .do_w(dw0), .do_sum(sm0), .do_acc(ac0), .acc_sub(sb0), .bit_idx(bt0),
        .busy(bs0), .rom_cen(cn0), .rom_wen(wn0), .rom_addr(ad0), .rom_loaded(lo0));

    da_control_gen #(.DATA_W(8), .NPART(2), .ROM_WORDS(64), .SIGNED(0)) dut1 (
        .clk(clk), .resetn(resetn), .cload(cload), .coef_valid(coef_valid), .in_valid(in_valid),
        .in_ready(ir1), .out_valid(ov1), .out_ready(out_ready), .load_sreg(ls1), .clr_acc(ca1),
        .shift_sreg(ss1), .do_w(dw1), .do_sum(sm1), .do_acc(ac1), .acc_sub(sb1), .bit_idx(bt1),
        .busy(bs1), .rom_cen(cn1), .rom_wen(wn1), .rom_addr(ad1), .rom_loaded(lo1));

    localparam logic [31:0] RST_V = 32'h180;
    logic [31:0] act0, act1;
    assign act0 = {2'b0, ir0, ov0, ls0, ca0, ss0, 4'b0, dw0, sm0, ac0, sb0, bt0, bs0, cn0, wn0, ad0, lo0};
    assign act1 = {2'b0, ir1, ov1, ls1, ca1, ss1, 6'b0, dw1, sm1, ac1, sb1, 1'b0, bt1, bs1, cn1, wn1, ad1, lo1};

    int n_vec = 0, n_err = 0;

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Schedule model: t counts falling edges since acceptance; each slice is NPART lookups, sum, acc, then a shift
    int PP[2] = '{4, 2};
    int DD[2] = '{16, 8};
    int SS[2] = '{1, 0};
    logic [31:0] exp_v [2];
    int m_ph[2], m_t[2], m_beats[2], m_bit[2];
    bit m_loaded[2], m_rdy[2];

    always @(negedge clk or negedge resetn) begin
        logic wr, iv, ov, ld, cl, sh, sm, ac, sb, bs, cn, wn;
        logic [7:0] dw;
        logic [3:0] bt;
        logic [5:0] ad;
        int idx, j, r, p, d;
        for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
                m_ph[i] = 0; m_t[i] = 0; m_beats[i] = 0; m_bit[i] = 0; m_loaded[i] = 0; m_rdy[i] = 0;
                exp_v[i] = RST_V;
            end else begin
                p = PP[i]; d = DD[i];
                wr = 0;
                m_loaded[i] = m_loaded[i] | (m_beats[i] >= 64);
                case (m_ph[i])
                    0: if (cload) wr = coef_valid;
                       else if (in_valid && m_rdy[i]) begin m_ph[i] = 1; m_t[i] = 0; end
                    1: begin m_t[i]++; if (m_t[i] == d * (p + 3)) m_ph[i] = 2; end
                    default: if (out_ready) m_ph[i] = 0;
                endcase
                {iv, ov, ld, cl, sh, sm, ac, sb} = '0;
                dw = 0; ad = 0; cn = 1; wn = 1;
                bs = m_ph[i] != 0;
                bt = 4'(m_bit[i]);
                if (m_ph[i] == 0) begin
                    ad = 6'(m_beats[i] % 64);
                    if (wr) begin cn = 0; wn = 0; m_beats[i]++; end
                    iv = m_loaded[i] && !cload;
                end else if (m_ph[i] == 2) begin
                    ov = 1; bt = 4'(d - 1);
                end else if (m_t[i] == 0) begin
                    ld = 1; cl = 1; bt = 0;
                end else begin
                    idx = m_t[i] - 1; j = idx / (p + 3); r = idx % (p + 3);
                    bt = 4'(j);
                    if (r < p) begin dw = 8'(1 << r); cn = 0; ad = 6'(r * (64 / p)); end
                    else if (r == p) sm = 1;
                    else if (r == p + 1) begin ac = 1; sb = SS[i] != 0 && j == d - 1; end
                    else begin sh = 1; bt = 4'(j + 1); end
                end
                m_bit[i] = int'(bt);
                m_rdy[i] = iv;
                exp_v[i] = {2'b0, iv, ov, ld, cl, sh, dw, sm, ac, sb, bt, bs, cn, wn, ad, m_loaded[i]};
            end
        end
    end

    always @(negedge clk) begin
        #1;
        check("model_default", act0, exp_v[0]);
        check("model_variant", act1, exp_v[1]);
    end

    initial begin
        int n, lat0, lat1, nw, badw, nacc, nsh, nsub, sub_at, nsub1, n32, bada1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_default", act0, RST_V);
        check("reset_variant", act1, RST_V);
        @(posedge clk);
        resetn = 1; in_valid = 1;
        repeat (5) begin
            @(negedge clk); #1;
            check("noload_in_ready", 32'(ir0), 0);
            check("noload_busy", 32'(bs0), 0);
        end
        @(posedge clk);
        in_valid = 0; cload = 1; coef_valid = 1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk); #1;
            check("beat_addr", 32'(ad0), 32'(i));
            check("beat_cen_wen", 32'({cn0, wn0}), 0);
            check("beat_loaded", 32'(lo0), 0);
        end
        @(posedge clk); coef_valid = 0;
        @(negedge clk); #1;
        check("wrap_loaded", 32'(lo0), 1);
        check("wrap_addr", 32'(ad0), 0);
        check("wrap_wen", 32'(wn0), 1);
        @(posedge clk); coef_valid = 1;
        @(negedge clk); #1;
        check("beat65_addr", 32'(ad0), 0);
        check("beat65_wen", 32'(wn0), 0);
        @(posedge clk); coef_valid = 0; cload = 0;
        @(negedge clk); #1;
        check("ready_after_load", 32'(ir0), 1);
        @(posedge clk); in_valid = 1;
        @(negedge clk); #1;
        check("accept_fetch", 32'({ls0, ca0, bs0}), 32'h7);
        @(posedge clk); in_valid = 0;
        n = 0; lat0 = -1; lat1 = -1; nw = 0; badw = 0; nacc = 0; nsh = 0;
        nsub = 0; sub_at = 0; nsub1 = 0; n32 = 0; bada1 = 0;
        while (lat0 < 0 && n < 300) begin
            @(negedge clk); #1;
            n++;
            if (dw0 != 0) begin
                if (dw0 != 4'(1 << (nw % 4))) badw++;
                nw++;
            end
            if (ac0) nacc++;
            if (ss0) nsh++;
            if (sb0) begin nsub++; sub_at = nacc; end
            if (sb1) nsub1++;
            if (!cn1) begin
                if (ad1 == 6'd32) n32++;
                else if (ad1 != 6'd0) bada1++;
            end
            if (ov0) lat0 = n;
            if (ov1 && lat1 < 0) lat1 = n;
        end
        check("latency_default", 32'(lat0), 112);
        check("latency_variant", 32'(lat1), 40);
        check("do_w_count", 32'(nw), 64);
        check("do_w_order", 32'(badw), 0);
        check("do_acc_count", 32'(nacc), 16);
        check("shift_count", 32'(nsh), 15);
        check("acc_sub_count", 32'(nsub), 1);
        check("acc_sub_on_16th", 32'(sub_at), 16);
        check("variant_acc_sub", 32'(nsub1), 0);
        check("variant_addr32", 32'(n32), 8);
        check("variant_addr_other", 32'(bada1), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("hold_out_valid", 32'(ov0), 1);
            check("hold_strobes", 32'({ls0, ss0, sm0, ac0, dw0}), 0);
        end
        @(posedge clk); out_ready = 1;
        @(negedge clk); #1;
        check("release_idle", 32'({bs0, ov0, ir0, bs1}), 32'h2);
        @(posedge clk); out_ready = 0; in_valid = 1;
        @(negedge clk); #1;
        check("accept2_fetch", 32'(ls0), 1);
        @(posedge clk); in_valid = 0;
        n = 0;
        while (bt0 != 4'd7 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        check("reach_bit7", 32'(bt0), 7);
        @(posedge clk); #2;
        resetn = 0;
        #1;
        check("midreset_default", act0, RST_V);
        check("midreset_variant", act1, RST_V);
        @(posedge clk);
        resetn = 1; in_valid = 1;
        repeat (3) begin
            @(negedge clk); #1;
            check("reload_needed", 32'({ir0, bs0, lo0}), 0);
        end
        in_valid = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/da_control_gen.md
Name: da_control_gen

Overview:
- Parametrised control FSM for the distributed-arithmetic (DA) FIR datapath.
- Sequences coefficient-ROM loading, bit-serial input processing, per-partition ROM lookups, partial-sum add, shift-accumulate with an optional two's-complement sign-bit subtract, and result hand-off.
- Replaces fixed-width start/done sequencing with valid/ready handshakes on input and output.
- Sits between the sample stream, the shared single-port coefficient ROM and the DA datapath (shift registers, adder, accumulator).

Parameters:
- DATA_W, 16, input sample width; one bit-slice iteration per bit.
- NPART, 4, number of ROM partitions looked up per bit-slice, 1..8.
- ROM_WORDS, 64, total ROM words; must be a multiple of NPART.
- SIGNED, 1, 1: subtract the MSB slice; 0: add all slices.

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- resetn  in  1  asynchronous active-low reset.
- cload  in  1  coefficient-load mode request.
- coef_valid  in  1  a ROM word is present on the datapath write bus.
- in_valid  in  1  sample available.
- in_ready  out  1  controller accepts a sample.
- out_valid  out  1  accumulator holds a finished result.
- out_ready  in  1  consumer takes the result.
- load_sreg  out  1  parallel-load the input shift registers.
- clr_acc  out  1  clear the accumulator.
- shift_sreg  out  1  shift the input registers by one bit.
- do_w  out  NPART  one-hot lookup-register strobe, one bit per partition.
- do_sum  out  1  add the partition results.
- do_acc  out  1  accumulator shift-and-add.
- acc_sub  out  1  accumulate by subtraction (qualifies do_acc).
- bit_idx  out  clog2(DATA_W)  current bit-slice index.
- busy  out  1  high in any state other than IDLE.
- rom_cen  out  1  ROM chip enable, active-low.
- rom_wen  out  1  ROM write enable, active-low.
- rom_addr  out  clog2(ROM_WORDS)  ROM base/write address.
- rom_loaded  out  1  a full ROM image has been written.

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low. Every output is registered and updated on the falling edge of clk, so the datapath samples stable controls on the rising edge.
- Reset values: state IDLE, rom_addr 0, bit_idx 0, rom_loaded 0, rom_cen 1, rom_wen 1. Every other output 0.
- Reset mid-operation: applies these values immediately. ROM contents are untouched but rom_loaded is cleared, so a reload is required.
- State IDLE:
  - in_ready = rom_loaded & ~cload.
  - cload & coef_valid: rom_cen=0, rom_wen=0 for that cycle; rom_addr increments after the write.
  - At rom_addr = ROM_WORDS-1, rom_addr wraps to 0 and rom_loaded is set. rom_loaded stays 1 until reset.
  - cload takes priority over in_valid. Load beats outside IDLE are ignored.
  - in_valid & in_ready -> FETCH.
- State FETCH (1 cycle): load_sreg=1, clr_acc=1, bit_idx=0 -> LOOKUP with k=0.
- State LOOKUP (NPART cycles):
  - do_w[k]=1, rom_cen=0, rom_wen=1, rom_addr = k*(ROM_WORDS/NPART).
  - The datapath ORs the bit-slice address into the low bits.
  - k = NPART-1 -> SUM.
- State SUM (1 cycle): do_sum=1 -> ACC.
- State ACC (1 cycle):
  - do_acc=1; acc_sub = SIGNED & (bit_idx = DATA_W-1).
  - bit_idx = DATA_W-1 -> DONE; otherwise -> SHIFT.
- State SHIFT (1 cycle): shift_sreg=1, bit_idx increments -> LOOKUP with k=0.
- State DONE:
  - out_valid=1, held with the accumulator frozen until out_ready.
  - out_ready -> IDLE. in_ready is low in DONE.
- Latency: sample accepted to out_valid = 1 + DATA_W*(NPART+2) + (DATA_W-1) falling edges. With defaults this is 112.
- Ignored inputs: in_valid while busy, and cload while busy.
- Illegal or unreachable state: go to IDLE with reset output values, keeping rom_loaded.
- Exclusivity: exactly one of load_sreg, do_w, do_sum, do_acc, shift_sreg is active in any non-IDLE cycle except DONE, where none is active.

Test Plan:
- Load and wrap:
  - Stimulus: reset, cload=1, 64 coef_valid beats.
  - Required: rom_wen/rom_cen low on each beat, rom_addr 0..63.
  - Required: rom_loaded rises after beat 64, rom_addr returns to 0.
  - Required: a 65th beat writes address 0.
- Start before load: in_valid=1 with rom_loaded=0 -> in_ready=0, busy stays 0.
- Full run with defaults:
  - Stimulus: accept one sample.
  - Required: out_valid rises exactly 112 falling edges later.
  - Required: do_w strobes 1,2,4,8 cycle by cycle each slice; 16 do_acc pulses; 15 shift_sreg pulses.
  - Required: acc_sub=1 only on the 16th do_acc.
- Output backpressure:
  - Stimulus: out_ready=0 for 10 cycles, then 1.
  - Required: out_valid held for 10 cycles, no strobes during the hold, IDLE on the next edge.
- Reset mid-operation: resetn low at bit_idx=7 -> all outputs at reset values immediately, rom_loaded=0.
- Parameter variant:
  - Configuration: NPART=2, DATA_W=8, SIGNED=0.
  - Required: latency 1+8*4+7=40; acc_sub never asserts.
  - Required: rom_addr alternates between 0 and 32.
